// File: rtl/alu_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_streamer
// Description : Captures an alu result on a done rising edge and streams it
//               as bytes over valid/ready (row-major matrix or one det byte).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_streamer #(
    parameter int MAX_N  = 5,
    parameter int ELEM_W = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          done,
    input  logic [2:0]                    opcode,
    input  logic [2:0]                    matrix_size,
    input  logic [MAX_N*MAX_N*ELEM_W-1:0] C_flat,
    input  logic [ELEM_W-1:0]             number,
    input  logic                          overflow_flag,
    output logic [ELEM_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          out_ovf,
    output logic                          busy,
    output logic                          drop
);

    localparam int         FLAT_W = MAX_N * MAX_N * ELEM_W;
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_DET = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state;
    logic                det_mode;
    logic                done_q;
    logic [FLAT_W-1:0]   mat;
    logic [2:0]          n;
    logic [2:0]          row;
    logic [2:0]          col;

    logic                start;
    logic                capture;
    logic                beat;
    logic                load;
    logic                cap_det;
    logic                cap_last;
    logic [2:0]          cap_n;
    logic [ELEM_W-1:0]   cap_data;
    logic [2:0]          nxt_row;
    logic [2:0]          nxt_col;
    logic                nxt_last;
    logic [ELEM_W-1:0]   nxt_elem;

    // Indices past the end of the flat bus only occur after the final element
    // and are never loaded, so they simply read as zero.
    function automatic logic [ELEM_W-1:0] elem_at(input logic [FLAT_W-1:0] flat,
                                                  input logic [2:0] r,
                                                  input logic [2:0] c);
        int idx;
        idx = (int'(r) * MAX_N + int'(c)) * ELEM_W;
        if (idx > FLAT_W - ELEM_W) begin
            return '0;
        end
        return flat[idx +: ELEM_W];
    endfunction

    always_comb begin
        start    = done & ~done_q;
        capture  = start & (opcode != OP_NOP);
        beat     = out_valid & out_ready;
        // A new result may be taken from idle or on the very beat that ends the current one.
        load     = capture & ((state == IDLE) | (beat & out_last));
        cap_det  = (opcode == OP_DET);

        if (matrix_size == 3'd0) begin
            cap_n = 3'd1;
        end else if (int'(matrix_size) > MAX_N) begin
            cap_n = 3'(MAX_N);
        end else begin
            cap_n = matrix_size;
        end

        cap_data = cap_det ? number : C_flat[ELEM_W-1:0];
        cap_last = cap_det | (cap_n == 3'd1);

        if (col == n - 3'd1) begin
            nxt_col = 3'd0;
            nxt_row = row + 3'd1;
        end else begin
            nxt_col = col + 3'd1;
            nxt_row = row;
        end
        nxt_last = (nxt_row == n - 3'd1) && (nxt_col == n - 3'd1);
        nxt_elem = elem_at(mat, nxt_row, nxt_col);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            det_mode  <= 1'b0;
            done_q    <= 1'b0;
            mat       <= '0;
            n         <= 3'd0;
            row       <= 3'd0;
            col       <= 3'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            done_q <= done;
            drop   <= 1'b0;
            if (load) begin
                state     <= SEND;
                det_mode  <= cap_det;
                mat       <= C_flat;
                n         <= cap_n;
                row       <= 3'd0;
                col       <= 3'd0;
                out_data  <= cap_data;
                out_last  <= cap_last;
                out_ovf   <= overflow_flag;
                out_valid <= 1'b1;
                busy      <= 1'b1;
            end else if (state == SEND) begin
                if (capture) begin
                    drop <= 1'b1;
                end
                if (beat) begin
                    if (out_last) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        out_last  <= 1'b0;
                        out_ovf   <= 1'b0;
                        out_data  <= '0;
                    end else if (!det_mode) begin
                        row      <= nxt_row;
                        col      <= nxt_col;
                        out_data <= nxt_elem;
                        out_last <= nxt_last;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_streamer.sv
`default_nettype none
// Directed bench for alu_result_streamer: matrix/det streams, backpressure,
// collisions, reset mid-stream and size/opcode edge cases.
module tb_alu_result_streamer;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         done = 1'b0;
    logic [2:0]   opcode = 3'd0;
    logic [2:0]   matrix_size = 3'd0;
    logic [199:0] C_flat = '0;
    logic [7:0]   number = 8'd0;
    logic         overflow_flag = 1'b0;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic         out_ovf;
    logic         busy;
    logic         drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   exp_data [0:24];
    logic [199:0] pat;
    logic [199:0] bp;

    alu_result_streamer #(.MAX_N(5), .ELEM_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .done(done), .opcode(opcode),
        .matrix_size(matrix_size), .C_flat(C_flat), .number(number),
        .overflow_flag(overflow_flag), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_ovf(out_ovf),
        .busy(busy), .drop(drop)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Row-major expected bytes for an n x n read of a 5-wide flat bus.
    task automatic fill_exp(input int n, input logic [199:0] cf);
        for (int k = 0; k < n * n; k++) begin
            exp_data[k] = cf[((k / n) * 5 + (k % n)) * 8 +: 8];
        end
    endtask

    task automatic start_op(input logic [2:0] op, input logic [2:0] sz, input logic [199:0] cf,
                            input logic [7:0] num, input logic ovf);
        @(negedge clock);
        opcode = op; matrix_size = sz; C_flat = cf; number = num; overflow_flag = ovf;
        out_ready = 1'b0;
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_busy", {31'd0, busy}, 32'd1);
    endtask

    // inject_kind: 0 none, 1 foreign result (must be dropped), 2 det 0x5A (back-to-back)
    task automatic run_stream(input string tag, input int nexp, input int ready_mode,
                              input logic exp_ovf, input int inject_at, input int inject_kind,
                              input bit expect_idle_after);
        int got = 0;
        int cyc = 0;
        int drops = 0;
        bit stalled = 1'b0;
        bit injected = 1'b0;
        logic [7:0] held = 8'd0;
        while (got < nexp && cyc < 300) begin
            done = 1'b0;
            out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (drop) drops++;
            if (stalled) check({tag, "_stall_data"}, {24'd0, out_data}, {24'd0, held});
            if (inject_kind != 0 && !injected && inject_at == got) begin
                injected = 1'b1;
                done = 1'b1;
                if (inject_kind == 1) begin
                    C_flat = ~C_flat; opcode = 3'b001;
                end else begin
                    opcode = 3'b111; number = 8'h5A; overflow_flag = 1'b0;
                end
            end
            if (out_valid && out_ready) begin
                check($sformatf("%s_data%0d", tag, got), {24'd0, out_data}, {24'd0, exp_data[got]});
                check($sformatf("%s_last%0d", tag, got), {31'd0, out_last}, {31'd0, got == nexp - 1});
                check($sformatf("%s_ovf%0d", tag, got), {31'd0, out_ovf}, {31'd0, exp_ovf});
                got++;
                stalled = 1'b0;
            end else begin
                check({tag, "_valid_held"}, {31'd0, out_valid}, 32'd1);
                stalled = out_valid;
                held = out_data;
            end
            cyc++;
            @(negedge clock);
        end
        done = 1'b0;
        check({tag, "_beats"}, got, nexp);
        check({tag, "_drops"}, drops, (inject_kind == 1) ? 1 : 0);
        if (expect_idle_after) begin
            check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
            check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        for (int i = 0; i < 25; i++) pat[i*8 +: 8] = 8'(i * 11 + 3);
        bp = '0;
        bp[0*8 +: 8] = 8'h11; bp[1*8 +: 8] = 8'h22;
        bp[5*8 +: 8] = 8'h33; bp[6*8 +: 8] = 8'h44;

        repeat (3) @(negedge clock);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_drop", {31'd0, drop}, 32'd0);
        reset_n = 1'b1;

        // 5x5 matrix stream from the hand-written vector
        exp_data = '{8'hE4, 8'h02, 8'h40, 8'h03, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        start_op(3'b001, 3'd5, 200'h01_00_00_00_00_00_02_02_00_03_40_02_E4, 8'h00, 1'b0);
        run_stream("mat5", 25, 0, 1'b0, -1, 0, 1'b1);

        // backpressure 2x2
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
        start_op(3'b010, 3'd2, bp, 8'h00, 1'b0);
        run_stream("bp", 4, 1, 1'b0, -1, 0, 1'b1);

        // determinant
        exp_data[0] = 8'hF6;
        start_op(3'b111, 3'd3, pat, 8'hF6, 1'b1);
        run_stream("det", 1, 0, 1'b1, -1, 0, 1'b1);

        // collision mid-stream is dropped
        fill_exp(3, pat);
        start_op(3'b001, 3'd3, pat, 8'h00, 1'b0);
        run_stream("drop", 9, 0, 1'b0, 2, 1, 1'b1);

        // collision on final beat streams back-to-back
        fill_exp(3, pat);
        start_op(3'b011, 3'd3, pat, 8'h00, 1'b1);
        run_stream("b2b_mat", 9, 0, 1'b1, 8, 2, 1'b0);
        check("b2b_no_gap_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_no_gap_data", {24'd0, out_data}, 32'h5A);
        exp_data[0] = 8'h5A;
        run_stream("b2b_det", 1, 0, 1'b0, -1, 0, 1'b1);

        // reset mid-stream
        fill_exp(3, pat);
        start_op(3'b001, 3'd3, pat, 8'h00, 1'b1);
        out_ready = 1'b1;
        repeat (4) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_data", {24'd0, out_data}, 32'd0);
        check("rstmid_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (out_valid || busy) seen++;
        end
        check("rstmid_idle_after", seen, 0);

        // done held high for 10 cycles gives one capture
        @(negedge clock);
        opcode = 3'b001; matrix_size = 3'd1; C_flat = pat; out_ready = 1'b1; done = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 10) done = 1'b0;
            if (out_valid && out_ready) seen++;
            @(negedge clock);
        end
        check("held_done_beats", seen, 1);

        // size 0 clamps to 1
        exp_data[0] = pat[7:0];
        start_op(3'b001, 3'd0, pat, 8'h00, 1'b0);
        run_stream("size0", 1, 0, 1'b0, -1, 0, 1'b1);

        // size 7 clamps to 5
        fill_exp(5, pat);
        start_op(3'b100, 3'd7, pat, 8'h00, 1'b0);
        run_stream("size7", 25, 0, 1'b0, -1, 0, 1'b1);

        // opcode 000 is a no-op
        @(negedge clock);
        opcode = 3'b000; matrix_size = 3'd3; out_ready = 1'b1; done = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) done = 1'b0;
            @(negedge clock);
            if (out_valid || busy || drop) seen++;
        end
        check("nop_no_output", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_streamer.md
# alu_result_streamer

Sequential read-out stage on the result side of the matrix `alu`. It captures `C_flat`, `number` and `overflow_flag` when the `alu` raises `done`. It then serialises the result as signed bytes over a valid/ready stream toward the host or bus bridge:
- row-major n×n elements for matrix operations;
- a single byte for the determinant.

This lets the host read results without a 200-bit parallel path.

## Interface
Parameters:
- `MAX_N`, 5: matrix dimension of the flat bus (element stride 8 bits, row stride `MAX_N` elements).
- `ELEM_W`, 8: element width in bits.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `done`  in  1  `alu` completion; a rising edge starts a capture.
- `opcode`  in  3  `alu` opcode associated with `done`.
- `matrix_size`  in  3  n, valid range 1..5.
- `C_flat`  in  200  `alu` matrix result; element (r,c) at bits [(r*5+c)*8 +: 8].
- `number`  in  8  `alu` determinant result.
- `overflow_flag`  in  1  `alu` overflow.
- `out_data`  out  8  current stream byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the byte.
- `out_last`  out  1  current byte is the final byte of the result.
- `out_ovf`  out  1  latched overflow of the result being streamed.
- `busy`  out  1  high while streaming.
- `drop`  out  1  one-cycle pulse: a `done` edge was ignored.

## Operation
- Edge detect:
  - `done_q` registers `done`.
  - A start is `done & ~done_q`.
  - A `done` held high does not retrigger.
- FSM states are `IDLE` and `SEND`.
- `IDLE` with start and opcode != 000:
  - Latch `C_flat`, `number`, `overflow_flag` and the size.
  - Clear `r` and `c`.
  - Set mode `DET` if opcode = 111, else `MAT`.
  - Go to `SEND`.
- `IDLE` with start and opcode = 000 (no-op): ignored; no `drop` pulse.
- Size clamp: 0 is treated as 1; 6 and 7 are treated as 5.
- `SEND`, `MAT` mode:
  - `out_data` is the latched element (r,c).
  - On a beat (`out_valid & out_ready`), c increments.
  - When c = n-1, c returns to 0 and r increments.
  - After element (n-1,n-1) is accepted, the FSM returns to `IDLE`.
- `SEND`, `DET` mode:
  - `out_data` is the latched `number`.
  - One beat, then the FSM returns to `IDLE`.
- `out_last`:
  - `MAT`: high when r = c = n-1.
  - `DET`: always high.
- `out_ovf` holds the latched `overflow_flag` for the whole of `SEND`.
- A start during `SEND` that is not on the final beat:
  - Ignored; `drop` pulses 1 cycle.
  - The current stream is unaffected.
- A start coincident with the final beat:
  - Captured; `drop` stays low.
  - The FSM stays in `SEND` and the new result begins next cycle (back-to-back).
- `out_data` and `out_last` stay stable while `out_valid & ~out_ready`.
- `out_valid` never drops without a beat.
- Reset, asynchronous, including mid-stream:
  - All outputs go low: `out_data` = 0x00 and `out_valid`, `out_last`, `out_ovf`, `busy`, `drop` = 0.
  - `done_q` goes to 0 and state to `IDLE`.
  - Partial stream is discarded; no resume.
- Data is passed through unmodified: no sign extension and no arithmetic on elements.

## Timing
- Latency: a start sampled at edge k gives `out_valid`, `busy` and the first `out_data` registered at edge k.
  - They are visible throughout cycle k+1.
  - That is 1 cycle from the `done` rise to the first byte.
- Throughput is 1 byte per cycle with `out_ready` held high.
  - An n×n result takes n² cycles.
  - A determinant takes 1 cycle.
- `busy` equals `out_valid`; both fall at the edge that accepts the last beat, unless a back-to-back capture occurs.
- `drop` is registered, high for exactly the cycle after the ignored start.
- All outputs are registered; there is no combinational path from `out_ready` to `out_valid`.

## Test plan
- Reset mid-stream:
  - Stimulus: n=3 stream at beat 4, assert `reset_n`=0 between edges.
  - Required: `out_valid`, `busy`, `out_data` go to 0 immediately.
  - Required after release: the FSM is idle until the next `done` edge.
- Matrix stream:
  - Stimulus: n=5, `C_flat`=200'h…_01_00_00_00_00_00_02_02_00_03_40_02_E4, opcode 001, `done` 0→1, `out_ready`=1.
  - Required: 25 beats, first bytes E4, 02, 40, 03, 00, 02, 02, …; `out_last` only on beat 25; `busy` low after.
- Backpressure:
  - Stimulus: n=2, `out_ready` toggling 1,0,0,1,….
  - Required: each byte held stable while stalled; order (0,0),(0,1),(1,0),(1,1); exactly 4 beats.
- Determinant:
  - Stimulus: opcode 111, `number`=8'hF6, `overflow_flag`=1.
  - Required: single beat F6 with `out_last`=1 and `out_ovf`=1.
- Collisions:
  - Stimulus: a second `done` edge at beat 2 of a 3×3 stream.
  - Required: `drop` pulses once and 9 beats are unchanged.
  - Stimulus: a `done` edge on the final beat.
  - Required: the new result streams starting the next cycle with no idle gap.
- Edge cases:
  - `done` held high for 10 cycles gives exactly 1 capture.
  - `matrix_size`=0 gives a 1-beat stream of element (0,0).
  - `matrix_size`=7 gives 25 beats.
  - opcode 000 gives no output.
